// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, FSM states, acc-source and ALU codes for ctrl_fsm
//
// Purpose: common definitions imported by ctrl_decode and ctrl_fsm.
// Contents: opcode values OP_*, FSM state enum state_e (S_*),
//           accumulator source codes SEL_*, ALU operation codes ALU_*,
//           and the decoded control bundle dec_t.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  typedef struct packed {
    logic       ld_acc;
    logic [1:0] sel_acc;
    logic [2:0] alu_op;
    logic       reg_we;
    logic       jmp;
    logic       jz;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decoder for ctrl_fsm
//
// Purpose: maps IR[7:4] to ungated control fields; the FSM applies state gating.
// Ports:
//   opcode_i  in  4      IR[7:4]
//   dec_o     out dec_t  {ld_acc, sel_acc, alu_op, reg_we, jmp, jz, halt}
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_LDI: begin
        dec_o.ld_acc  = 1'b1;
        dec_o.sel_acc = SEL_IMM;
      end
      OP_LDR: begin
        dec_o.ld_acc  = 1'b1;
        dec_o.sel_acc = SEL_REG;
      end
      OP_STR:  dec_o.reg_we = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        dec_o.ld_acc  = 1'b1;
        dec_o.sel_acc = SEL_ALU;
        // opcode-4 modulo 8 equals opcode[2:0]+4 modulo 8 over 4..B
        dec_o.alu_op  = opcode_i[2:0] + 3'd4;
      end
      OP_JMP:  dec_o.jmp  = 1'b1;
      OP_JZ:   dec_o.jz   = 1'b1;
      OP_HALT: dec_o.halt = 1'b1;
      default: dec_o = '0;  // NOP and reserved opcode
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - FETCH/DECODE/EXECUTE sequencer owning PC and IR
//
// Purpose: multi-cycle control unit; one instruction per 3 clocks, HALT parks
// the machine until CLB. Optional feature macro: CTRL_SINGLE_STEP_EN (adds
// port step; FETCH waits for step=1).
// Ports:
//   clk       in   1       clock, rising edge
//   CLB       in   1       async active-low clear
//   instr     in   8       program memory data at address pc
//   acc_zero  in   1       accumulator is zero
//   step      in   1       single-step pulse (CTRL_SINGLE_STEP_EN only)
//   pc        out  PC_W    program counter
//   loadAcc   out  1       accumulator load strobe (EXECUTE only)
//   sel_acc   out  2       accumulator source select
//   imm       out  4       IR[3:0]
//   alu_op    out  3       ALU operation
//   reg_addr  out  REG_AW  register-file address IR[REG_AW-1:0]
//   reg_we    out  1       register-file write strobe (EXECUTE only)
//   halted    out  1       machine is in HALT
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic [7:0]        instr,
  input  logic              acc_zero,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [PC_W-1:0]   pc,
  output logic              loadAcc,
  output logic [1:0]        sel_acc,
  output logic [3:0]        imm,
  output logic [2:0]        alu_op,
  output logic [REG_AW-1:0] reg_addr,
  output logic              reg_we,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  dec_t              dec;
  logic              fetch_go;

`ifdef CTRL_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  ctrl_decode u_decode (
    .opcode_i (ir_q[7:4]),
    .dec_o    (dec)
  );

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec.halt) begin
          // pc stays at the HALT instruction's address
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          if (dec.jmp || (dec.jz && acc_zero)) begin
            pc_d = PC_W'(ir_q[3:0]);
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are combinational on state_q so an async clear removes them at once.
  always_comb begin
    loadAcc  = 1'b0;
    reg_we   = 1'b0;
    if (state_q == S_EXEC) begin
      loadAcc = dec.ld_acc;
      reg_we  = dec.reg_we;
    end
    halted   = (state_q == S_HALT);
    pc       = pc_q;
    sel_acc  = dec.sel_acc;
    alu_op   = dec.alu_op;
    imm      = ir_q[3:0];
    reg_addr = ir_q[REG_AW-1:0];
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - self-checking bench for ctrl_fsm
module tb_ctrl_fsm;

  logic       clk = 1'b0;
  logic       CLB;
  logic [7:0] instr;
  logic       acc_zero;
  logic       step;
  logic [7:0] pc;
  logic       loadAcc;
  logic [1:0] sel_acc;
  logic [3:0] imm;
  logic [2:0] alu_op;
  logic [1:0] reg_addr;
  logic       reg_we;
  logic       halted;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ctrl_fsm #(.PC_W(8), .REG_AW(2)) dut (
    .clk      (clk),
    .CLB      (CLB),
    .instr    (instr),
    .acc_zero (acc_zero),
`ifdef CTRL_SINGLE_STEP_EN
    .step     (step),
`endif
    .pc       (pc),
    .loadAcc  (loadAcc),
    .sel_acc  (sel_acc),
    .imm      (imm),
    .alu_op   (alu_op),
    .reg_addr (reg_addr),
    .reg_we   (reg_we),
    .halted   (halted)
  );

  typedef struct {
    logic [7:0] ins;
    logic       az;
    int         ld;
    int         sel;
    int         alu;
    int         we;
    int         npc;
    int         hlt;
  } vec_t;

  typedef struct {
    int ld;
    int sel;
    int alu;
    int we;
    int npc;
  } exp_t;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
  endtask

  // Instruction-level reference: outcome of one instruction from opcode ranges.
  function automatic exp_t model(input logic [7:0] ins, input logic az, input int cur_pc);
    exp_t e;
    int op;
    op    = int'(ins[7:4]);
    e.ld  = (op == 1 || op == 2 || (op >= 4 && op <= 11)) ? 1 : 0;
    e.sel = (op == 1) ? 3 : (op == 2) ? 2 : 0;
    e.alu = (op >= 4 && op <= 11) ? op - 4 : 0;
    e.we  = (op == 3) ? 1 : 0;
    if (op == 12 || (op == 13 && az)) e.npc = int'(ins[3:0]);
    else e.npc = (cur_pc + 1) % 256;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    CLB = 1'b0;
    @(negedge clk);
    CLB = 1'b1;
  endtask

  // Entered on a negedge with the DUT in FETCH; returns one negedge after EXECUTE.
  task automatic run_instr(input logic [7:0] ins, input logic az, input int e_pc,
                           input int e_ld, input int e_sel, input int e_alu,
                           input int e_we, input int e_npc, input int e_hlt);
    chk("fetch_pc", int'(pc), e_pc);
    chk("fetch_strobes", int'({loadAcc, reg_we}), 0);
    instr    = ins;
    acc_zero = az;
    step     = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("dec_strobes", int'({loadAcc, reg_we}), 0);
    chk("dec_sel", int'(sel_acc), e_sel);
    chk("dec_alu", int'(alu_op), e_alu);
    chk("dec_imm", int'(imm), int'(ins[3:0]));
    chk("dec_reg_addr", int'(reg_addr), int'(ins[1:0]));
    @(negedge clk);
    chk("exe_loadAcc", int'(loadAcc), e_ld);
    chk("exe_reg_we", int'(reg_we), e_we);
    chk("exe_sel", int'(sel_acc), e_sel);
    chk("exe_alu", int'(alu_op), e_alu);
    chk("exe_halted", int'(halted), 0);
    instr = 8'($urandom);
    @(negedge clk);
    chk("next_pc", int'(pc), e_npc);
    chk("halted", int'(halted), e_hlt);
  endtask

  vec_t tbl[$];
  exp_t e;
  int   pc_m;
  logic [7:0] r_ins;
  logic r_az;

  initial begin
    CLB = 1'b0; instr = 8'h00; acc_zero = 1'b0; step = 1'b0;

    tbl.push_back('{8'h15, 1'b0, 1, 3, 0, 0, 1, 0});
    tbl.push_back('{8'h43, 1'b0, 1, 0, 0, 0, 2, 0});
    tbl.push_back('{8'h32, 1'b0, 0, 0, 0, 1, 3, 0});
    tbl.push_back('{8'h2A, 1'b0, 1, 2, 0, 0, 4, 0});
    tbl.push_back('{8'hD9, 1'b0, 0, 0, 0, 0, 5, 0});
    tbl.push_back('{8'h7F, 1'b1, 1, 0, 3, 0, 6, 0});
    tbl.push_back('{8'hB1, 1'b0, 1, 0, 7, 0, 7, 0});
    tbl.push_back('{8'hC4, 1'b0, 0, 0, 0, 0, 4, 0});
    tbl.push_back('{8'hD9, 1'b1, 0, 0, 0, 0, 9, 0});
    tbl.push_back('{8'h96, 1'b0, 1, 0, 5, 0, 10, 0});
    tbl.push_back('{8'hE5, 1'b1, 0, 0, 0, 0, 11, 0});
    tbl.push_back('{8'hC0, 1'b0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h5C, 1'b0, 1, 0, 1, 0, 1, 0});
    tbl.push_back('{8'h0F, 1'b1, 0, 0, 0, 0, 2, 0});

    // Reset values while CLB is held low
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_strobes", int'({loadAcc, reg_we}), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_ir_fields", int'({sel_acc, imm, alu_op, reg_addr}), 0);
    CLB = 1'b1;

    // Directed program table
    pc_m = 0;
    foreach (tbl[i]) begin
      run_instr(tbl[i].ins, tbl[i].az, pc_m, tbl[i].ld, tbl[i].sel, tbl[i].alu,
                tbl[i].we, tbl[i].npc, tbl[i].hlt);
      pc_m = tbl[i].npc;
    end

    // Clear during EXECUTE of LDI removes the strobe immediately
    do_reset();
    instr = 8'h15; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("mid_exec_ld", int'(loadAcc), 1);
    #1 CLB = 1'b0;
    #1;
    chk("clr_loadAcc", int'(loadAcc), 0);
    chk("clr_pc", int'(pc), 0);
    chk("clr_halted", int'(halted), 0);
    chk("clr_ir", int'({imm, sel_acc}), 0);
    @(negedge clk);
    CLB = 1'b1;

    // HALT at pc=7 parks the machine
    run_instr(8'hC7, 1'b0, 0, 0, 0, 0, 0, 7, 0);
    run_instr(8'hF0, 1'b0, 7, 0, 0, 0, 0, 7, 1);
    for (int k = 0; k < 20; k++) begin
      instr = 8'($urandom);
      acc_zero = 1'($urandom);
      step = 1'($urandom);
      @(negedge clk);
      chk("halt_pc", int'(pc), 7);
      chk("halt_flag", int'(halted), 1);
      chk("halt_strobes", int'({loadAcc, reg_we}), 0);
    end
    step = 1'b0;

    // PC wrap: NOPs from 0 to FF, then back to 00
    do_reset();
    for (int k = 0; k < 256; k++) begin
      run_instr(8'h00, 1'b0, k, 0, 0, 0, 0, (k + 1) % 256, 0);
    end

    // Random instruction stream against the instruction-level model
    do_reset();
    pc_m = 0;
    for (int k = 0; k < 300; k++) begin
      r_ins = 8'($urandom);
      if (r_ins[7:4] == 4'hF) r_ins[7:4] = 4'h0;
      r_az = 1'($urandom);
      e = model(r_ins, r_az, pc_m);
      run_instr(r_ins, r_az, pc_m, e.ld, e.sel, e.alu, e.we, e.npc, 0);
      pc_m = e.npc;
    end

`ifdef CTRL_SINGLE_STEP_EN
    // Without step the machine sits in FETCH; one pulse runs one instruction
    do_reset();
    step = 1'b0;
    for (int k = 0; k < 10; k++) begin
      instr = 8'h15;
      @(negedge clk);
      chk("ss_pc_frozen", int'(pc), 0);
      chk("ss_ir_frozen", int'(imm), 0);
      chk("ss_no_strobe", int'({loadAcc, reg_we}), 0);
    end
    run_instr(8'h15, 1'b0, 0, 1, 3, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ss_after_pc", int'(pc), 1);
      chk("ss_after_ld", int'(loadAcc), 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
